// File: rtl/hazard3_uart_dtm_tx.sv
// UART DTM transmitter: drains bytes from a valid/ready source and sends them as 8N1 frames.
// The bit period is clkdiv+1 clocks, latched per byte; consecutive bytes are sent without idle gaps.
`timescale 1ns/1ps
module hazard3_uart_dtm_tx #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] clkdiv,
  input  logic [7:0]           din,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic                 tx,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic [7:0]           shift, shift_next;
  logic [DIV_WIDTH-1:0] div, div_next;
  logic [DIV_WIDTH-1:0] timer, timer_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 tx_next;
  logic                 busy_next;
  logic                 timer_done;
  logic                 accept;

  localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  assign timer_done = (timer == '0);
  // Ready in the final stop-bit cycle lets the next start bit follow with no idle gap.
  assign din_rdy    = (state == S_IDLE) || ((state == S_STOP) && timer_done);
  assign accept     = din_vld && din_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shift   <= '0;
      div     <= '0;
      timer   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      div     <= div_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
      busy    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    div_next     = div;
    timer_next   = timer;
    bit_idx_next = bit_idx;
    tx_next      = tx;
    busy_next    = busy;

    case (state)
      S_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
      S_START: begin
        if (timer_done) begin
          state_next   = S_DATA;
          timer_next   = div;
          bit_idx_next = 3'd0;
          tx_next      = shift[0];
        end else begin
          timer_next = timer - ONE;
        end
      end
      S_DATA: begin
        if (timer_done) begin
          timer_next = div;
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
          end
        end else begin
          timer_next = timer - ONE;
        end
      end
      S_STOP: begin
        if (timer_done) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          tx_next    = 1'b1;
        end else begin
          timer_next = timer - ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase

    // Accept only happens in IDLE or at the end of STOP, so it cleanly overrides either.
    if (accept) begin
      state_next = S_START;
      shift_next = din;
      div_next   = clkdiv;
      timer_next = clkdiv;
      tx_next    = 1'b0;
      busy_next  = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard3_uart_dtm_tx.sv
// Directed bench for hazard3_uart_dtm_tx: table of byte streams with hand-computed 10-bit frames,
// plus idle, mid-frame clkdiv change and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_hazard3_uart_dtm_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] clkdiv;
  logic [7:0]  din;
  logic        din_vld;
  logic        din_rdy;
  logic        tx;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  hazard3_uart_dtm_tx #(.DIV_WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clkdiv  (clkdiv),
    .din     (din),
    .din_vld (din_vld),
    .din_rdy (din_rdy),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frames[f] bit i is the tx level during bit slot i (0 = start, 1..8 = data LSB first, 9 = stop)
  typedef struct {
    logic [15:0]      div;
    int               nbytes;
    logic [2:0][7:0]  bytes;
    logic [2:0][9:0]  frames;
    logic [2:0][15:0] divs;
    int               chg_k;
    logic [15:0]      chg_div;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int len;
    int per;
    int frame_err;
    clkdiv = v.div;
    @(negedge clk);
    din     = v.bytes[0];
    din_vld = 1'b1;
    check("rdy_before_accept", din_rdy, 1'b1);
    for (int f = 0; f < v.nbytes; f++) begin
      per       = int'(v.divs[f]) + 1;
      len       = 10 * per;
      frame_err = failures;
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        check("tx_bit", tx, v.frames[f][k / per]);
        check("busy_in_frame", busy, 1'b1);
        check("rdy_in_frame", din_rdy, (k == len - 1));
        if (k == 0) din_vld = 1'b0;
        if (f == 0 && k == v.chg_k) clkdiv = v.chg_div;
        if (k == len - 1 && f < v.nbytes - 1) begin
          din     = v.bytes[f + 1];
          din_vld = 1'b1;
        end
      end
      $display("TXN vec=%0d frame=%0d byte=%02h div=%0d cycles=%0d errors=%0d",
               id, f, v.bytes[f], v.divs[f], len, failures - frame_err);
    end
    @(negedge clk);
    check("tx_idle_after", tx, 1'b1);
    check("busy_idle_after", busy, 1'b0);
    check("rdy_idle_after", din_rdy, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    clkdiv  = 16'd0;
    din     = 8'h00;
    din_vld = 1'b0;

    // 0x55: 1_01010101_0
    vecs[0] = '{div: 16'd3, nbytes: 1, bytes: {8'h00, 8'h00, 8'h55},
                frames: {10'h000, 10'h000, 10'h2AA}, divs: {16'd0, 16'd0, 16'd3},
                chg_k: -1, chg_div: 16'd0};
    // 0xA5 -> 0x34A, 0x3C -> 0x278, gapless
    vecs[1] = '{div: 16'd3, nbytes: 2, bytes: {8'h00, 8'h3C, 8'hA5},
                frames: {10'h000, 10'h278, 10'h34A}, divs: {16'd0, 16'd3, 16'd3},
                chg_k: -1, chg_div: 16'd0};
    // clkdiv=0: 0xFF -> 0x3FE, 0x00 -> 0x200, 0x81 -> 0x302
    vecs[2] = '{div: 16'd0, nbytes: 3, bytes: {8'h81, 8'h00, 8'hFF},
                frames: {10'h302, 10'h200, 10'h3FE}, divs: {16'd0, 16'd0, 16'd0},
                chg_k: -1, chg_div: 16'd0};
    // clkdiv 7 -> 1 at cycle 20 of the first frame; 0x3C -> 0x278, 0x5A -> 0x2B4
    vecs[3] = '{div: 16'd7, nbytes: 2, bytes: {8'h00, 8'h5A, 8'h3C},
                frames: {10'h000, 10'h2B4, 10'h278}, divs: {16'd0, 16'd1, 16'd7},
                chg_k: 20, chg_div: 16'd1};
    // frame after mid-frame reset: 0xC3 -> 1_11000011_0 = 0x386
    vecs[4] = '{div: 16'd3, nbytes: 1, bytes: {8'h00, 8'h00, 8'hC3},
                frames: {10'h000, 10'h000, 10'h386}, divs: {16'd0, 16'd0, 16'd3},
                chg_k: -1, chg_div: 16'd0};

    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rdy", din_rdy, 1'b1);
    rst_n = 1'b1;

    // Idle with din_vld low for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_rdy", din_rdy, 1'b1);
    end
    $display("TXN idle cycles=100");

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Mid-frame reset: 0x55 at clkdiv=3, reset during cycle 17 (bit slot 4 = d3 = 0)
    clkdiv = 16'd3;
    @(negedge clk);
    din     = 8'h55;
    din_vld = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) din_vld = 1'b0;
    end
    check("pre_reset_tx", tx, 1'b0);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_rdy", din_rdy, 1'b1);
    $display("TXN reset mid-frame at cycle 17");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_rdy", din_rdy, 1'b1);
    check("post_reset_tx", tx, 1'b1);
    run_vec(4, vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
